// File: rtl/scu_pipe_pkg.sv
// Shared encodings and helpers for the scu_pipe stall/flush control unit.
// STALL_BUS expands against the N_STAGE parameter of the including scope.
`ifndef SCU_PIPE_PKG_SV
`define SCU_PIPE_PKG_SV
`define STALL_BUS [N_STAGE-1:0]

package scu_pipe_pkg;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NOSTOP     = 1'b0;

    typedef enum logic [0:0] {
        SCU_IDLE = 1'b0,
        SCU_PEND = 1'b1
    } scu_state_e;

    // Index width for a stage number; never narrower than one bit.
    function automatic int src_width(input int n_stage);
        return (n_stage > 1) ? $clog2(n_stage) : 1;
    endfunction

endpackage

`endif

// File: rtl/scu_pipe_thermo.sv
// scu_thermo: turns a stage index into a thermometer mask (bits 0..idx set).
module scu_thermo
    import scu_pipe_pkg::*;
#(
    parameter int N_STAGE = 5,
    parameter int SRC_W   = 3
) (
    input  logic               en,
    input  logic [SRC_W-1:0]   idx,
    output logic [N_STAGE-1:0] mask
);

    // Thermometer expansion, gated by the enable.
    always_comb begin
        mask = {N_STAGE{NOSTOP}};
        for (int i = 0; i < N_STAGE; i++) begin
            if (en && (i <= int'(idx))) begin
                mask[i] = STOP;
            end else begin
                mask[i] = NOSTOP;
            end
        end
    end

endmodule

// File: rtl/scu_pipe.sv
// scu_pipe: stall/flush control for an N_STAGE in-order pipeline.
// Optional macro SCU_PERF_EN adds 32-bit stall/flush performance counters.
module scu_pipe
    import scu_pipe_pkg::*;
#(
    parameter int N_STAGE = 5,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200,
    localparam int SRC_W  = src_width(N_STAGE)
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic               global_stall_req,
    input  logic [N_STAGE-1:0] stage_stall_req,
    input  logic               flush_req,
    input  logic [SRC_W-1:0]   flush_src,
    output logic [N_STAGE-1:0] stall,
    output logic [N_STAGE-1:0] flush,
    output logic               flush_pend,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               stall_timeout
`ifdef SCU_PERF_EN
    ,
    output logic [31:0]        perf_global_cnt,
    output logic [31:0]        perf_local_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam logic [SRC_W-1:0] LAST_IDX   = SRC_W'(N_STAGE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    scu_state_e       state_r;
    logic [SRC_W-1:0] pend_src_r;
    logic             flush_pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_r;

    logic [SRC_W-1:0] src_clamp_s;
    logic [SRC_W-1:0] hi_idx_s;
    logic [SRC_W-1:0] src_eff_s;
    logic             any_req_s;
    logic             flush_live_s;
    logic             flush_act_s;
    logic             stall_any_s;
    logic `STALL_BUS  local_mask_s;
    logic `STALL_BUS  flush_mask_s;

    // Out-of-range flush sources collapse onto the oldest stage.
    always_comb begin
        if (flush_src > LAST_IDX) begin
            src_clamp_s = LAST_IDX;
        end else begin
            src_clamp_s = flush_src;
        end
    end

    // Highest requesting stage; later iterations win.
    always_comb begin
        hi_idx_s  = '0;
        any_req_s = 1'b0;
        for (int i = 0; i < N_STAGE; i++) begin
            hi_idx_s  = stage_stall_req[i] ? SRC_W'(i) : hi_idx_s;
            any_req_s = any_req_s | stage_stall_req[i];
        end
    end

    // Effective flush source: a pending flush merges with a new one, older stage wins.
    always_comb begin
        case (state_r)
            SCU_IDLE: begin
                flush_live_s = flush_req;
                src_eff_s    = src_clamp_s;
            end
            SCU_PEND: begin
                flush_live_s = 1'b1;
                if (flush_req && (src_clamp_s > pend_src_r)) begin
                    src_eff_s = src_clamp_s;
                end else begin
                    src_eff_s = pend_src_r;
                end
            end
            default: begin
                flush_live_s = 1'b0;
                src_eff_s    = '0;
            end
        endcase
    end

    assign flush_act_s = (cpu_rst_n != RST_ENABLE) && !global_stall_req && flush_live_s;

    scu_thermo #(.N_STAGE(N_STAGE), .SRC_W(SRC_W)) u_stall_thermo (
        .en   (any_req_s),
        .idx  (hi_idx_s),
        .mask (local_mask_s)
    );

    scu_thermo #(.N_STAGE(N_STAGE), .SRC_W(SRC_W)) u_flush_thermo (
        .en   (flush_act_s),
        .idx  (src_eff_s),
        .mask (flush_mask_s)
    );

    // Stage enables: reset forces zero, global stall dominates, flushed stages drop their stall.
    always_comb begin
        if (cpu_rst_n == RST_ENABLE) begin
            stall = {N_STAGE{NOSTOP}};
            flush = {N_STAGE{NOSTOP}};
        end else if (global_stall_req) begin
            stall = {N_STAGE{STOP}};
            flush = {N_STAGE{NOSTOP}};
        end else begin
            flush = flush_mask_s;
            stall = local_mask_s & ~flush_mask_s;
        end
    end

    assign stall_any_s = |stall;

    // Flush sequencing FSM: hold a flush while the global stall is up, fire when it drops.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            state_r      <= SCU_IDLE;
            pend_src_r   <= '0;
            flush_pend_r <= 1'b0;
        end else begin
            case (state_r)
                SCU_IDLE: begin
                    if (flush_req && global_stall_req) begin
                        state_r      <= SCU_PEND;
                        pend_src_r   <= src_clamp_s;
                        flush_pend_r <= 1'b1;
                    end else begin
                        state_r      <= SCU_IDLE;
                        pend_src_r   <= pend_src_r;
                        flush_pend_r <= 1'b0;
                    end
                end
                SCU_PEND: begin
                    if (global_stall_req) begin
                        state_r      <= SCU_PEND;
                        pend_src_r   <= src_eff_s;
                        flush_pend_r <= 1'b1;
                    end else begin
                        state_r      <= SCU_IDLE;
                        pend_src_r   <= '0;
                        flush_pend_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= SCU_IDLE;
                    pend_src_r   <= '0;
                    flush_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Consecutive stall length with saturation, plus the sticky-while-stalled timeout flag.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else if (!stall_any_s) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            if (cnt_r >= TIMEOUT_M1) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign flush_pend    = flush_pend_r;
    assign stall_cycles  = cnt_r;
    assign stall_timeout = timeout_r;

`ifdef SCU_PERF_EN
    logic [31:0] perf_global_r;
    logic [31:0] perf_local_r;
    logic [31:0] perf_flush_r;

    // Free-running, wrapping event counters.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (cpu_rst_n == RST_ENABLE) begin
            perf_global_r <= 32'd0;
            perf_local_r  <= 32'd0;
            perf_flush_r  <= 32'd0;
        end else begin
            perf_global_r <= perf_global_r + {31'd0, global_stall_req};
            perf_local_r  <= perf_local_r + {31'd0, (!global_stall_req && any_req_s)};
            perf_flush_r  <= perf_flush_r + {31'd0, (|flush)};
        end
    end

    assign perf_global_cnt = perf_global_r;
    assign perf_local_cnt  = perf_local_r;
    assign perf_flush_cnt  = perf_flush_r;
`endif

endmodule
